// File: rtl/nios_project_13_poll_pkg.sv
// Shared definitions for the PIO poller: poll FSM encoding and a width helper.
package nios_project_13_poll_pkg;

  // Poll sequencer states: count idle cycles, issue the read, wait for data.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } poll_state_e;

  // Bits needed to hold values 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/nios_project_13_poll_timer.sv
// Reloadable down counter with count enable, synchronous reload and zero flag.
// It stops at zero; the owner decides when to reload.
module nios_project_13_poll_timer #(
  parameter int            W      = 10,
  parameter logic [W-1:0]  RELOAD = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         reload,
  output logic [W-1:0] count,
  output logic         zero
);

  // Count register: reload has priority over decrement, and it never wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= RELOAD;
    end else if (reload) begin
      count <= RELOAD;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/nios_project_13_pio_poller.sv
// Avalon-MM master that periodically reads one PIO register and turns value
// changes into valid/ready events carrying the new value and a changed mask.
//
// Event handshake: evt_valid/evt_data/evt_changed form a valid/ready source.
// A transfer happens on any clock edge where evt_valid=1 and evt_ready=1.
// Once raised, evt_valid stays high until that transfer; while waiting, the
// payload changes only when a newer change is merged in (which sets overrun).
module nios_project_13_pio_poller
  import nios_project_13_poll_pkg::*;
#(
  parameter int DATA_W       = 1,
  parameter int ADDR_W       = 2,
  parameter int TARGET_ADDR  = 0,
  parameter int POLL_CYCLES  = 1000,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [DATA_W-1:0] evt_data,
  output logic [DATA_W-1:0] evt_changed,
  output logic              overrun,
  input  logic              overrun_clr,
  output logic [1:0]        poll_state
);

  localparam int               CNT_W      = clog2(POLL_CYCLES);
  localparam int               LAT_W      = clog2(READ_LATENCY);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(POLL_CYCLES - 1);
  localparam logic [LAT_W-1:0] LAT_RELOAD = LAT_W'(READ_LATENCY - 1);

  poll_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt;
  logic               cnt_zero;
  logic               cnt_en, cnt_reload;
  logic [LAT_W-1:0]   lat_q;
  logic               rd_accept;
  logic               sample_fire;
  logic [DATA_W-1:0]  sample;
  logic [DATA_W-1:0]  mask;
  logic [DATA_W-1:0]  baseline_q;
  logic               primed_q;
  logic               new_change, evt_load, evt_merge;
  logic               unused_ok;

  assign avm_address = ADDR_W'(TARGET_ADDR);
  assign poll_state  = state_q;

  // Only the low DATA_W bits of the read word are meaningful.
  assign unused_ok = &{1'b0, avm_readdata};

  // Idle-gap counter runs only in IDLE with enable high; it reloads on the
  // cycle the read is launched so the next gap starts full.
  assign cnt_en     = (state_q == IDLE) && enable && !cnt_zero;
  assign cnt_reload = (state_q == IDLE) && enable &&  cnt_zero;

  nios_project_13_poll_timer #(
    .W      (CNT_W),
    .RELOAD (CNT_RELOAD)
  ) u_poll_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (cnt_en),
    .reload  (cnt_reload),
    .count   (cnt),
    .zero    (cnt_zero)
  );

  assign rd_accept   = avm_read && !avm_waitrequest;
  assign sample_fire = (state_q == WAIT) && (lat_q == '0);
  assign sample      = avm_readdata[DATA_W-1:0];
  assign mask        = sample ^ baseline_q;
  assign new_change  = sample_fire && primed_q && (mask != '0);
  assign evt_load    = new_change && (!evt_valid || evt_ready);
  assign evt_merge   = new_change && evt_valid && !evt_ready;

  // Next-state logic; a started transaction always runs to completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable && cnt_zero) state_d = REQ;
      REQ:     if (rd_accept)          state_d = WAIT;
      WAIT:    if (lat_q == '0)        state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  // State register plus the registered read strobe, held through waitrequest.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      avm_read <= 1'b0;
    end else begin
      state_q  <= state_d;
      avm_read <= (state_d == REQ);
    end
  end

  // Read-latency countdown, armed when the slave accepts the read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_q <= LAT_RELOAD;
    end else if (rd_accept) begin
      lat_q <= LAT_RELOAD;
    end else if ((state_q == WAIT) && (lat_q != '0)) begin
      lat_q <= lat_q - LAT_W'(1);
    end
  end

  // Baseline tracks the last sample; the first sample after reset only primes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      baseline_q <= '0;
      primed_q   <= 1'b0;
    end else if (sample_fire) begin
      baseline_q <= sample;
      primed_q   <= 1'b1;
    end
  end

  // Event register: load a fresh event, merge into a pending one, or retire
  // the current one on transfer. Overrun set wins over a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      evt_valid   <= 1'b0;
      evt_data    <= '0;
      evt_changed <= '0;
      overrun     <= 1'b0;
    end else begin
      if (evt_load) begin
        evt_valid   <= 1'b1;
        evt_data    <= sample;
        evt_changed <= mask;
      end else if (evt_merge) begin
        evt_data    <= sample;
        evt_changed <= evt_changed | mask;
      end else if (evt_valid && evt_ready) begin
        evt_valid   <= 1'b0;
      end
      if (evt_merge) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nios_project_13_pio_poller.sv
// Self-checking bench for the PIO poller with a bus-level event model.
module tb_nios_project_13_pio_poller;
  import nios_project_13_poll_pkg::*;

  localparam int DATA_W       = 4;
  localparam int ADDR_W       = 2;
  localparam int TARGET_ADDR  = 2;
  localparam int POLL_CYCLES  = 4;
  localparam int READ_LATENCY = 1;
  localparam int PERIOD       = POLL_CYCLES + READ_LATENCY + 1;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              enable;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_waitrequest;
  logic [31:0]       avm_readdata;
  logic              evt_valid;
  logic              evt_ready;
  logic [DATA_W-1:0] evt_data;
  logic [DATA_W-1:0] evt_changed;
  logic              overrun;
  logic              overrun_clr;
  logic [1:0]        poll_state;

  logic [DATA_W-1:0] slave_val;
  logic [31:0]       junk;
  int                n_cmp;
  int                n_err;

  assign avm_readdata = {junk[31:DATA_W], slave_val};

  // Clock and DUT
  always #5 clk = ~clk;

  nios_project_13_pio_poller #(
    .DATA_W       (DATA_W),
    .ADDR_W       (ADDR_W),
    .TARGET_ADDR  (TARGET_ADDR),
    .POLL_CYCLES  (POLL_CYCLES),
    .READ_LATENCY (READ_LATENCY)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .enable          (enable),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata),
    .evt_valid       (evt_valid),
    .evt_ready       (evt_ready),
    .evt_data        (evt_data),
    .evt_changed     (evt_changed),
    .overrun         (overrun),
    .overrun_clr     (overrun_clr),
    .poll_state      (poll_state)
  );

  // Reference model: a sample is the read word READ_LATENCY edges after the
  // slave accepts a read; events follow the change/merge/accept rules.
  logic              m_valid, m_ov, m_primed;
  logic [DATA_W-1:0] m_data, m_changed, m_base;
  int                m_pend;
  logic              t_valid, t_ov, t_primed;
  logic [DATA_W-1:0] t_data, t_changed, t_base, t_s;
  int                t_pend;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_valid <= 1'b0; m_ov <= 1'b0; m_primed <= 1'b0;
      m_data <= '0; m_changed <= '0; m_base <= '0; m_pend <= 0;
    end else begin
      t_valid = m_valid; t_ov = m_ov; t_primed = m_primed;
      t_data = m_data; t_changed = m_changed; t_base = m_base; t_pend = m_pend;
      if (m_valid && evt_ready) t_valid = 1'b0;
      if (overrun_clr) t_ov = 1'b0;
      if (t_pend > 0) begin
        t_pend = t_pend - 1;
        if (t_pend == 0) begin
          t_s = avm_readdata[DATA_W-1:0];
          if (!m_primed) begin
            t_base = t_s; t_primed = 1'b1;
          end else if (t_s != m_base) begin
            t_base = t_s;
            t_data = t_s;
            if (!m_valid || evt_ready) begin
              t_changed = t_s ^ m_base; t_valid = 1'b1;
            end else begin
              t_changed = m_changed | (t_s ^ m_base); t_ov = 1'b1;
            end
          end
        end
      end
      if (avm_read && !avm_waitrequest) t_pend = READ_LATENCY;
      m_valid <= t_valid; m_ov <= t_ov; m_primed <= t_primed;
      m_data <= t_data; m_changed <= t_changed; m_base <= t_base; m_pend <= t_pend;
    end
  end

  // Driver tasks
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_read(input int limit, output logic ok);
    ok = 1'b0;
    for (int k = 0; k < limit; k++) begin
      tick();
      if (avm_read) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; enable = 1'b0; avm_waitrequest = 1'b0; evt_ready = 1'b0;
    overrun_clr = 1'b0; slave_val = '0; junk = '0;
    repeat (3) tick();
    n_cmp++;
    if ({avm_read, evt_valid, evt_data, evt_changed, overrun} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b expected 0", {avm_read, evt_valid, evt_data, evt_changed, overrun});
    end
    n_cmp++;
    if (avm_address !== ADDR_W'(TARGET_ADDR)) begin
      n_err++; $display("FAIL address: got %0d expected %0d", avm_address, TARGET_ADDR);
    end
    n_cmp++;
    if (poll_state !== IDLE) begin
      n_err++; $display("FAIL reset_state: got %0d expected %0d", poll_state, IDLE);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_prime_idle;
    int   rises[$];
    int   n_valid;
    logic prev;
    n_valid = 0;
    enable = 1'b1; slave_val = '0;
    prev = avm_read;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (avm_read && !prev) rises.push_back(i);
      prev = avm_read;
      if (evt_valid) n_valid++;
    end
    n_cmp++;
    if (n_valid != 0) begin
      n_err++; $display("FAIL prime_no_event: got %0d valid cycles expected 0", n_valid);
    end
    n_cmp++;
    if (rises.size() < 5) begin
      n_err++; $display("FAIL read_count: got %0d expected >=5", rises.size());
    end else begin
      n_cmp++;
      if (rises[0] != POLL_CYCLES - 1) begin
        n_err++; $display("FAIL first_read: got %0d expected %0d", rises[0], POLL_CYCLES - 1);
      end
      for (int j = 1; j < rises.size(); j++) begin
        n_cmp++;
        if (rises[j] - rises[j-1] != PERIOD) begin
          n_err++; $display("FAIL poll_period: got %0d expected %0d", rises[j] - rises[j-1], PERIOD);
        end
      end
    end
  endtask

  task automatic test_single_change;
    int                n_hi;
    logic [DATA_W-1:0] got_d, got_c;
    n_hi = 0; got_d = '0; got_c = '0;
    evt_ready = 1'b1; slave_val = 4'd1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (evt_valid) begin
        n_hi++; got_d = evt_data; got_c = evt_changed;
      end
    end
    n_cmp++;
    if (n_hi != 1) begin
      n_err++; $display("FAIL single_pulse: got %0d valid cycles expected 1", n_hi);
    end
    n_cmp++;
    if (got_d !== 4'd1 || got_c !== 4'd1) begin
      n_err++; $display("FAIL single_payload: got data=%h changed=%h expected 1/1", got_d, got_c);
    end
  endtask

  task automatic test_overrun;
    logic ok;
    slave_val = 4'd0; evt_ready = 1'b1;
    repeat (15) tick();
    evt_ready = 1'b0; slave_val = 4'd3;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (evt_valid) begin ok = 1'b1; break; end
    end
    n_cmp++;
    if (!ok || evt_data !== 4'd3 || evt_changed !== 4'd3 || overrun !== 1'b0) begin
      n_err++;
      $display("FAIL first_event: got valid=%b data=%h changed=%h ovr=%b expected 1/3/3/0", ok, evt_data, evt_changed, overrun);
    end
    slave_val = 4'd1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (evt_data == 4'd1) begin ok = 1'b1; break; end
    end
    n_cmp++;
    if (!ok || evt_valid !== 1'b1 || evt_changed !== 4'd3 || overrun !== 1'b1) begin
      n_err++;
      $display("FAIL merge: got seen=%b valid=%b changed=%h ovr=%b expected 1/1/3/1", ok, evt_valid, evt_changed, overrun);
    end
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    n_cmp++;
    if (evt_valid !== 1'b0 || overrun !== 1'b1) begin
      n_err++; $display("FAIL accept: got valid=%b ovr=%b expected 0/1", evt_valid, overrun);
    end
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_err++; $display("FAIL overrun_clr: got %b expected 0", overrun);
    end
  endtask

  task automatic test_waitrequest;
    logic              ok;
    int                n_rd;
    int                t;
    logic [DATA_W-1:0] base, b;
    evt_ready = 1'b1;
    base = m_base;
    slave_val = base;
    wait_read(20, ok);
    n_cmp++;
    if (!ok) begin
      n_err++; $display("FAIL wr_read_start: got no read expected read within 20");
    end
    avm_waitrequest = 1'b1;
    n_rd = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (avm_read) n_rd++;
    end
    avm_waitrequest = 1'b0;
    tick();
    if (avm_read) n_rd++;
    b = ~base;
    slave_val = b;
    n_cmp++;
    if (n_rd != 6) begin
      n_err++; $display("FAIL wr_read_held: got %0d expected 6", n_rd);
    end
    t = 6;
    ok = 1'b0;
    while (t < 30) begin
      tick();
      t++;
      if (avm_read) begin ok = 1'b1; break; end
    end
    n_cmp++;
    if (!ok || t != PERIOD + 5) begin
      n_err++; $display("FAIL wr_period: got %0d expected %0d", t, PERIOD + 5);
    end
    n_cmp++;
    if (evt_data !== b || evt_changed !== 4'hF) begin
      n_err++; $display("FAIL wr_sample: got data=%h changed=%h expected %h/f", evt_data, evt_changed, b);
    end
  endtask

  task automatic test_enable_drop;
    logic              ok;
    int                n_rd;
    int                lat;
    logic [DATA_W-1:0] v;
    slave_val = m_base; evt_ready = 1'b1;
    tick();
    wait_read(20, ok);
    v = ~m_base;
    slave_val = v; evt_ready = 1'b0;
    tick();
    enable = 1'b0;
    tick();
    n_cmp++;
    if (!ok || evt_valid !== 1'b1 || evt_data !== v || evt_changed !== 4'hF) begin
      n_err++;
      $display("FAIL ed_sample: got valid=%b data=%h changed=%h expected 1/%h/f", evt_valid, evt_data, evt_changed, v);
    end
    n_rd = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (avm_read) n_rd++;
    end
    n_cmp++;
    if (n_rd != 0) begin
      n_err++; $display("FAIL ed_no_read: got %0d reads expected 0", n_rd);
    end
    enable = 1'b1; evt_ready = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (avm_read) begin lat = i; break; end
    end
    n_cmp++;
    if (lat != POLL_CYCLES) begin
      n_err++; $display("FAIL ed_frozen: got %0d expected %0d", lat, POLL_CYCLES);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) slave_val = DATA_W'($urandom);
      evt_ready       = 1'($urandom_range(0, 1));
      avm_waitrequest = ($urandom_range(0, 3) == 0);
      overrun_clr     = ($urandom_range(0, 7) == 0);
      junk            = $urandom;
      tick();
      n_cmp++;
      if ({evt_valid, evt_data, evt_changed, overrun} !== {m_valid, m_data, m_changed, m_ov}) begin
        n_err++;
        $display("FAIL random_model: got v=%b d=%h c=%h o=%b expected v=%b d=%h c=%h o=%b",
                 evt_valid, evt_data, evt_changed, overrun, m_valid, m_data, m_changed, m_ov);
      end
    end
    avm_waitrequest = 1'b0; overrun_clr = 1'b0; evt_ready = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_reset_midtx;
    logic              ok;
    int                n_hi;
    logic [DATA_W-1:0] v;
    evt_ready = 1'b0;
    v = DATA_W'($urandom_range(1, 15));
    while (v == m_base) v = DATA_W'($urandom_range(1, 15));
    slave_val = v;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (evt_valid) begin ok = 1'b1; break; end
    end
    n_cmp++;
    if (!ok) begin
      n_err++; $display("FAIL rm_event: got no event expected one within 20");
    end
    wait_read(20, ok);
    tick();
    #1 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({avm_read, evt_valid, evt_data, evt_changed, overrun} !== '0) begin
      n_err++;
      $display("FAIL rm_async: got %b expected 0", {avm_read, evt_valid, evt_data, evt_changed, overrun});
    end
    @(negedge clk);
    tick();
    slave_val = ~v;
    reset_n = 1'b1;
    n_hi = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (evt_valid) n_hi++;
    end
    n_cmp++;
    if (n_hi != 0) begin
      n_err++; $display("FAIL rm_prime_only: got %0d valid cycles expected 0", n_hi);
    end
  endtask

  // Sequence and report
  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_prime_idle();
    test_single_change();
    test_overrun();
    test_waitrequest();
    test_enable_drop();
    test_random();
    test_reset_midtx();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
